// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving a 4-to-16 one-hot decoder: steps {a,b,c,d} through masked channels.
// Define SCAN_GRAY_EN to visit codes in Gray order instead of binary order.
module decoder_scan_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        mode,
    input  logic [15:0] mask,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        code_valid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned NCH    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CODE_W-1:0]   r_pos, w_pos_nxt;
    logic [CODE_W-1:0]   r_code, w_code_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [NCH-1:0]      r_mask, w_mask_nxt;
    logic                r_mode, w_mode_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;

    logic [NCH-1:0]      w_srch_mask;
    logic                w_first_found, w_next_found;
    logic [CODE_W-1:0]   w_first_pos, w_next_pos;

    // Order position -> select code; mask bits always index codes, not positions
    function automatic logic [CODE_W-1:0] pos2code(input logic [CODE_W-1:0] p);
`ifdef SCAN_GRAY_EN
        return p ^ (p >> 1);
`else
        return p;
`endif
    endfunction

    // Lowest enabled position (live mask in IDLE, latched mask in SCAN) and next one after r_pos
    always_comb begin
        w_srch_mask   = (r_state == ST_IDLE) ? mask : r_mask;
        w_first_found = 1'b0;
        w_first_pos   = '0;
        w_next_found  = 1'b0;
        w_next_pos    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_srch_mask[pos2code(CODE_W'(i))]) begin
                w_first_found = 1'b1;
                w_first_pos   = CODE_W'(i);
            end
            if ((i > int'(r_pos)) && r_mask[pos2code(CODE_W'(i))]) begin
                w_next_found = 1'b1;
                w_next_pos   = CODE_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_code_nxt  = r_code;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        w_mode_nxt  = r_mode;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !stop && w_first_found) begin
                    w_state_nxt = ST_SCAN;
                    w_mask_nxt  = mask;
                    w_mode_nxt  = mode;
                    w_pos_nxt   = w_first_pos;
                    w_code_nxt  = pos2code(w_first_pos);
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_pos_nxt   = '0;
                    w_code_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_next_found) begin
                        w_pos_nxt  = w_next_pos;
                        w_code_nxt = pos2code(w_next_pos);
                    end else if (r_mode) begin
                        // Wrap: w_first_pos searched r_mask since we are in SCAN
                        w_pos_nxt  = w_first_pos;
                        w_code_nxt = pos2code(w_first_pos);
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_pos_nxt   = '0;
                        w_code_nxt  = '0;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pos   <= '0;
            r_code  <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_mode  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_code  <= w_code_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
            r_mode  <= w_mode_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign a          = r_code[3];
    assign b          = r_code[2];
    assign c          = r_code[1];
    assign d          = r_code[0];
    assign code_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
